mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/fgba_mem_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fgba_mem_pkg.sv
// Shared definitions for the memory arbiter slice.
//   WIDTH_*     : access width encodings carried on m_width / s_width
//   arb_state_e : arbiter FSM state encoding
package fgba_mem_pkg;

   localparam logic [1:0] WIDTH_BYTE = 2'd0;
   localparam logic [1:0] WIDTH_HALF = 2'd1;
   localparam logic [1:0] WIDTH_WORD = 2'd2;

   // Master index width; covers the full 2..8 master range.
   localparam int GID_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select.
//   i_req        : per-master request vector
//   i_last_grant : index of the previously served master
//   o_winner     : first requester found starting at i_last_grant+1 (mod N)
//   o_any_req    : at least one request present
module rr_arbiter
   import fgba_mem_pkg::*;
#(
   parameter int NUM_MASTERS = 3
) (
   input  logic [NUM_MASTERS-1:0] i_req,
   input  logic [GID_W-1:0]       i_last_grant,
   output logic [GID_W-1:0]       o_winner,
   output logic                   o_any_req
);

   // Padded to 8 so a 3-bit index always addresses a real bit.
   logic [7:0] w_req8;
   assign w_req8 = 8'(i_req);

   // Scan from the farthest offset down to +1 so the nearest requester
   // after the last grant overwrites any earlier hit.
   always_comb begin
      logic [GID_W-1:0] w_idx;
      w_idx     = '0;
      o_winner  = '0;
      o_any_req = 1'b0;
      for (int off = NUM_MASTERS; off >= 1; off--) begin
         w_idx = GID_W'((int'(i_last_grant) + off) % NUM_MASTERS);
         if (w_req8[w_idx]) begin
            o_winner  = w_idx;
            o_any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// N-master to single-slave memory arbiter with round-robin fairness and
// slave timeout.
//   clk, rstn          : clock, async active-low reset
//   m_addr/m_wdata/m_width/m_read/m_write : packed per-master requests
//   m_ok/m_err         : one-cycle completion / timeout pulse to the owner
//   m_rdata            : shared read data, valid while m_ok is high
//   s_*                : registered slave request / slave response
//   grant_id, busy     : current owner index, transaction in flight
module mem_arbiter
   import fgba_mem_pkg::*;
#(
   parameter int NUM_MASTERS = 3,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT     = 255
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
   input  logic [NUM_MASTERS*2-1:0]      m_width,
   input  logic [NUM_MASTERS-1:0]        m_read,
   input  logic [NUM_MASTERS-1:0]        m_write,
   output logic [NUM_MASTERS-1:0]        m_ok,
   output logic [NUM_MASTERS-1:0]        m_err,
   output logic [DATA_W-1:0]             m_rdata,
   output logic [ADDR_W-1:0]             s_addr,
   output logic [DATA_W-1:0]             s_wdata,
   output logic [1:0]                    s_width,
   output logic                          s_read,
   output logic                          s_write,
   input  logic [DATA_W-1:0]             s_rdata,
   input  logic                          s_ok,
   output logic [2:0]                    grant_id,
   output logic                          busy
);

   localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

   arb_state_e       r_state, w_state_nxt;
   logic [GID_W-1:0] r_grant, r_last_grant, w_winner;
   logic             w_any_req;
   logic [NUM_MASTERS-1:0] w_req;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata, r_rdata;
   logic [1:0]        r_width;
   logic              r_write, r_err;
   logic [15:0]       r_cnt;
   logic              w_timeout;

   // Per-master fields unpacked into 8-entry arrays so the 3-bit winner
   // index selects directly; unused entries read as zero.
   logic [ADDR_W-1:0] w_addr_a  [8];
   logic [DATA_W-1:0] w_wdata_a [8];
   logic [1:0]        w_width_a [8];
   logic [7:0]        w_wr8;

   genvar g;
   generate
      for (g = 0; g < 8; g++) begin : g_slice
         if (g < NUM_MASTERS) begin : g_on
            assign w_addr_a[g]  = m_addr[g*ADDR_W +: ADDR_W];
            assign w_wdata_a[g] = m_wdata[g*DATA_W +: DATA_W];
            assign w_width_a[g] = m_width[g*2 +: 2];
         end else begin : g_off
            assign w_addr_a[g]  = '0;
            assign w_wdata_a[g] = '0;
            assign w_width_a[g] = '0;
         end
      end
   endgenerate

   // Write strobe dominates: read+write together is a write.
   assign w_wr8     = 8'(m_write);
   assign w_req     = m_read | m_write;
   assign w_timeout = (r_cnt == TO_CNT);

   rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_rr (
      .i_req        (w_req),
      .i_last_grant (r_last_grant),
      .o_winner     (w_winner),
      .o_any_req    (w_any_req)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_any_req) w_state_nxt = ST_BUSY;
         ST_BUSY: if (s_ok || w_timeout) w_state_nxt = ST_RESP;
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_grant      <= '0;
         r_last_grant <= GID_W'(NUM_MASTERS - 1);
         r_addr       <= '0;
         r_wdata      <= '0;
         r_width      <= '0;
         r_write      <= 1'b0;
         r_err        <= 1'b0;
         r_rdata      <= '0;
         r_cnt        <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (w_any_req) begin
               r_grant <= w_winner;
               r_addr  <= w_addr_a[w_winner];
               r_wdata <= w_wdata_a[w_winner];
               r_width <= w_width_a[w_winner];
               r_write <= w_wr8[w_winner];
               r_err   <= 1'b0;
               r_cnt   <= '0;
            end
            ST_BUSY: begin
               // s_ok beats a timeout landing in the same cycle.
               if (s_ok) begin
                  r_rdata <= s_rdata;
                  r_cnt   <= '0;
               end else if (w_timeout) begin
                  r_err <= 1'b1;
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            ST_RESP: r_last_grant <= r_grant;
            default: ;
         endcase
      end
   end

   generate
      for (g = 0; g < NUM_MASTERS; g++) begin : g_resp
         assign m_ok[g]  = (r_state == ST_RESP) && (r_grant == GID_W'(g));
         assign m_err[g] = (r_state == ST_RESP) && (r_grant == GID_W'(g)) && r_err;
      end
   endgenerate

   assign m_rdata  = r_rdata;
   assign s_addr   = r_addr;
   assign s_wdata  = r_wdata;
   assign s_width  = r_width;
   assign s_read   = (r_state == ST_BUSY) && !r_write;
   assign s_write  = (r_state == ST_BUSY) && r_write;
   assign grant_id = r_grant;
   assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (3 masters, TIMEOUT=4) with a response
// scoreboard: expected completions are queued when the slave response is
// driven and popped when m_ok appears.
module tb_mem_arbiter;
   import fgba_mem_pkg::*;

   localparam int NM = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic [NM*AW-1:0]  m_addr = '0;
   logic [NM*DW-1:0]  m_wdata = '0;
   logic [NM*2-1:0]   m_width = '0;
   logic [NM-1:0]     m_read = '0, m_write = '0;
   logic [NM-1:0]     m_ok, m_err;
   logic [DW-1:0]     m_rdata;
   logic [AW-1:0]     s_addr;
   logic [DW-1:0]     s_wdata;
   logic [1:0]        s_width;
   logic              s_read, s_write;
   logic [DW-1:0]     s_rdata = '0;
   logic              s_ok = 1'b0;
   logic [2:0]        grant_id;
   logic              busy;

   mem_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rstn(rstn),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_width(m_width),
      .m_read(m_read), .m_write(m_write),
      .m_ok(m_ok), .m_err(m_err), .m_rdata(m_rdata),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_width(s_width),
      .s_read(s_read), .s_write(s_write),
      .s_rdata(s_rdata), .s_ok(s_ok),
      .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          mid;
      logic [31:0] rdata;
      logic        err;
      logic        chk_rd;
   } exp_t;
   exp_t sbq[$];

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input int i, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] w);
      m_addr[i*AW +: AW]  = a;
      m_wdata[i*DW +: DW] = d;
      m_width[i*2 +: 2]   = w;
   endtask

   task automatic push_exp(input int mid, input logic [31:0] rd, input logic err,
                           input logic chk_rd);
      exp_t e;
      e.mid = mid; e.rdata = rd; e.err = err; e.chk_rd = chk_rd;
      sbq.push_back(e);
   endtask

   // Ticks until a slave strobe appears (bounded); ncyc = ticks taken.
   task automatic wait_grant(input string tag, output int ncyc);
      ncyc = 0;
      do begin tick(); ncyc++; end while (!(s_read || s_write) && ncyc < 20);
      chk({tag, "_granted"}, 64'(s_read || s_write), 64'(1));
   endtask

   // Holds off nwait cycles, optionally answers, then waits (bounded) for
   // m_ok and checks it against the scoreboard head.
   task automatic finish_txn(input string tag, input int nwait, input logic give,
                             input logic [31:0] data, output int ncyc);
      exp_t e;
      ncyc = 0;
      repeat (nwait) begin tick(); ncyc++; end
      if (give) begin s_ok = 1'b1; s_rdata = data; end
      do begin tick(); ncyc++; s_ok = 1'b0; end while (m_ok == '0 && ncyc < 40);
      if (sbq.size() == 0) begin
         chk({tag, "_unexpected_ok"}, 64'(m_ok), 64'(0));
      end else begin
         e = sbq.pop_front();
         chk({tag, "_m_ok"}, 64'(m_ok), 64'(1) << e.mid);
         chk({tag, "_m_err"}, 64'(m_err), e.err ? (64'(1) << e.mid) : 64'(0));
         if (e.chk_rd) chk({tag, "_rdata"}, 64'(m_rdata), 64'(e.rdata));
      end
   endtask

   initial begin
      int n, n2, exp_id;
      logic [31:0] fa [NM];

      // Reset state
      #12;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_m_ok", 64'(m_ok), 64'(0));
      chk("rst_m_err", 64'(m_err), 64'(0));
      chk("rst_strobes", 64'({s_read, s_write}), 64'(0));
      chk("rst_gid", 64'(grant_id), 64'(0));
      chk("rst_saddr", 64'(s_addr), 64'(0));
      @(negedge clk); rstn = 1'b1;
      tick();

      // Master 1 read, slave answers after 2 cycles
      set_m(1, 32'h0300_0010, 32'h0, WIDTH_WORD);
      m_read[1] = 1'b1;
      wait_grant("A", n);
      chk("A_grant_lat", 64'(n), 64'(1));
      chk("A_gid", 64'(grant_id), 64'(1));
      chk("A_strobes", 64'({s_read, s_write}), 64'(2'b10));
      chk("A_saddr", 64'(s_addr), 64'(32'h0300_0010));
      m_read = '0;
      push_exp(1, 32'hDEAD_BEEF, 1'b0, 1'b1);
      finish_txn("A", 1, 1'b1, 32'hDEAD_BEEF, n);
      chk("A_ok_lat", 64'(n), 64'(2));
      tick();
      chk("A_idle_busy", 64'(busy), 64'(0));
      chk("A_idle_ok", 64'(m_ok), 64'(0));

      // Master 2 half-word write (read+write together), fields then disturbed
      set_m(2, 32'h0200_0000, 32'h0000_1234, WIDTH_HALF);
      m_read[2] = 1'b1; m_write[2] = 1'b1;
      wait_grant("C", n);
      chk("C_gid", 64'(grant_id), 64'(2));
      chk("C_strobes", 64'({s_read, s_write}), 64'(2'b01));
      chk("C_swidth", 64'(s_width), 64'(WIDTH_HALF));
      chk("C_saddr", 64'(s_addr), 64'(32'h0200_0000));
      chk("C_swdata", 64'(s_wdata), 64'(32'h0000_1234));
      set_m(2, 32'hFFFF_FFFF, 32'h0000_0BAD, WIDTH_BYTE);
      m_read = '0; m_write = '0;
      tick(); tick();
      chk("C_hold_strobes", 64'({s_read, s_write}), 64'(2'b01));
      chk("C_hold_swidth", 64'(s_width), 64'(WIDTH_HALF));
      chk("C_hold_saddr", 64'(s_addr), 64'(32'h0200_0000));
      chk("C_hold_swdata", 64'(s_wdata), 64'(32'h0000_1234));
      push_exp(2, 32'h0, 1'b0, 1'b0);
      finish_txn("C", 0, 1'b1, 32'h5555_5555, n);
      tick();

      // Timeout on master 0 while master 1 also waits
      set_m(0, 32'h1000_0000, 32'h0, WIDTH_WORD);
      set_m(1, 32'h1100_0000, 32'h0, WIDTH_WORD);
      m_read = 3'b011;
      wait_grant("D", n);
      chk("D_gid", 64'(grant_id), 64'(0));
      push_exp(0, 32'h0, 1'b1, 1'b0);
      finish_txn("D", 0, 1'b0, 32'h0, n2);
      chk("D_to_lat", 64'(n + n2), 64'(6));
      wait_grant("D_next", n);
      chk("D_next_gid", 64'(grant_id), 64'(1));
      m_read = '0;

      // s_ok on the exact cycle the counter reaches TIMEOUT
      push_exp(1, 32'hCAFE_F00D, 1'b0, 1'b1);
      finish_txn("E", TO, 1'b1, 32'hCAFE_F00D, n);
      chk("E_ok_lat", 64'(n), 64'(5));
      tick();

      // Reset asserted mid-BUSY; late s_ok after release
      m_read[1] = 1'b1;
      wait_grant("R", n);
      m_read = '0;
      tick();
      #2 rstn = 1'b0;
      #1;
      chk("R_busy", 64'(busy), 64'(0));
      chk("R_strobes", 64'({s_read, s_write}), 64'(0));
      chk("R_gid", 64'(grant_id), 64'(0));
      s_ok = 1'b1; s_rdata = 32'h0BAD_0BAD;
      @(negedge clk); rstn = 1'b1;
      tick(); tick();
      chk("R_late_ok", 64'(m_ok), 64'(0));
      chk("R_late_busy", 64'(busy), 64'(0));
      s_ok = 1'b0;

      // Fairness: all masters hold requests; master 0 first after reset
      for (int i = 0; i < NM; i++) begin
         fa[i] = 32'h4000_0000 + 32'(i) * 32'h100;
         set_m(i, fa[i], 32'h0, WIDTH_WORD);
      end
      m_read = '1;
      exp_id = 0;
      for (int t = 0; t < 6; t++) begin
         wait_grant($sformatf("F%0d", t), n);
         chk($sformatf("F%0d_gid", t), 64'(grant_id), 64'(exp_id));
         chk($sformatf("F%0d_saddr", t), 64'(s_addr), 64'(fa[exp_id]));
         push_exp(exp_id, 32'hA000_0000 + 32'(t), 1'b0, 1'b1);
         finish_txn($sformatf("F%0d", t), 0, 1'b1, 32'hA000_0000 + 32'(t), n);
         exp_id = (exp_id + 1) % NM;
      end
      m_read = '0;
      tick(); tick();
      chk("end_busy", 64'(busy), 64'(0));
      chk("end_sb_empty", 64'(sbq.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
